// File: rtl/sv32_ptw_pkg.sv
// Shared definitions for the Sv32 page-table walker and its TLB client.
// Holds PTE bit positions, virtual-address field positions, the walker state
// encoding and the bit layout of the 63-bit TLB update word.
package sv32_ptw_pkg;

  // PTE permission/valid bits
  localparam int unsigned PteV = 0;
  localparam int unsigned PteR = 1;
  localparam int unsigned PteW = 2;
  localparam int unsigned PteX = 3;

  // PTE PPN field; PPN[0] is bits 19:10 and must be zero for a 4 MiB leaf
  localparam int unsigned PtePpnLsb  = 10;
  localparam int unsigned PtePpn0Msb = 19;

  // Virtual-address fields
  localparam int unsigned VaVpn1Lsb = 22;
  localparam int unsigned VaVpn0Lsb = 12;
  localparam int unsigned VpnWidth  = 10;

  // Update word layout: {valid, is_4M, vpn[19:0], asid[8:0], content[31:0]}
  localparam int unsigned UpdWidth      = 63;
  localparam int unsigned UpdValidBit   = 62;
  localparam int unsigned UpdIs4MBit    = 61;
  localparam int unsigned UpdVpnLsb     = 41;
  localparam int unsigned UpdVpnWidth   = 20;
  localparam int unsigned UpdAsidLsb    = 32;
  localparam int unsigned UpdAsidWidth  = 9;
  localparam int unsigned UpdContentLsb = 0;

  // Walker states
  typedef logic [2:0] ptw_state_t;
  localparam ptw_state_t StIdle   = 3'd0;
  localparam ptw_state_t StL1Req  = 3'd1;
  localparam ptw_state_t StL1Wait = 3'd2;
  localparam ptw_state_t StL0Req  = 3'd3;
  localparam ptw_state_t StL0Wait = 3'd4;
  localparam ptw_state_t StUpdate = 3'd5;
  localparam ptw_state_t StFault  = 3'd6;
  localparam ptw_state_t StDrain  = 3'd7;

  // Physical address of a PTE: table base page plus 4-byte entry index
  function automatic logic [33:0] pte_addr(input logic [21:0] ppn, input logic [9:0] vpn);
    return {ppn, 12'b0} + {22'b0, vpn, 2'b00};
  endfunction

endpackage

// File: rtl/sv32_pte_check.sv
// Combinational Sv32 PTE classifier.
// Ports:
//   flags      in  4   PTE bits {X, W, R, V}
//   ppn0       in  10  PTE PPN[0] field (bits 19:10)
//   invalid    out 1   V clear, or write-only (reserved) encoding
//   leaf       out 1   valid PTE with R or X set
//   misaligned out 1   PPN[0] non-zero; only meaningful for a level-1 leaf
module sv32_pte_check
  import sv32_ptw_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [9:0] ppn0,
  output logic       invalid,
  output logic       leaf,
  output logic       misaligned
);

  always_comb begin
    invalid    = !flags[PteV] || (!flags[PteR] && flags[PteW]);
    leaf       = !invalid && (flags[PteR] || flags[PteX]);
    misaligned = (ppn0 != 10'd0);
  end

endmodule

// File: rtl/sv32_ptw.sv
// Sv32 hardware page-table walker.
// Accepts one TLB miss at a time, reads up to two PTEs (one outstanding memory
// request at most) and produces either a one-cycle TLB update or a one-cycle
// page-fault pulse. A flush aborts the walk; if a read is in flight the walker
// drains its response before returning to idle.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   flush_i                      abort walk
//   satp_ppn_i                   root table PPN
//   miss_valid_i/miss_ready_o    miss request handshake, with miss_vaddr_i, miss_asid_i
//   mem_req_valid_o/_ready_i     PTE read request, address mem_req_addr_o
//   mem_rsp_valid_i/_data_i      PTE read response
//   update_o                     TLB update word, zero except in the update cycle
//   walking_o                    walker busy
//   fault_valid_o/fault_vaddr_o  page-fault pulse and faulting vaddr
module sv32_ptw
  import sv32_ptw_pkg::*;
#(
  parameter int unsigned ASID_WIDTH = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [21:0]           satp_ppn_i,
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [31:0]           miss_vaddr_i,
  input  logic [ASID_WIDTH-1:0] miss_asid_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [33:0]           mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [31:0]           mem_rsp_data_i,
  output logic [62:0]           update_o,
  output logic                  walking_o,
  output logic                  fault_valid_o,
  output logic [31:0]           fault_vaddr_o
);

  ptw_state_t            state_q, state_d;
  logic [31:0]           vaddr_q, vaddr_d;
  logic [ASID_WIDTH-1:0] asid_q, asid_d;
  logic [31:0]           pte_q, pte_d;
  logic                  is_4m_q, is_4m_d;

  logic pte_invalid, pte_leaf, pte_misaligned;
  logic live;
  logic [UpdAsidWidth-1:0] asid_field;

  // Classify the response as it arrives so the WAIT states can branch on it.
  sv32_pte_check u_pte_check (
    .flags      (mem_rsp_data_i[PteX:PteV]),
    .ppn0       (mem_rsp_data_i[PtePpn0Msb:PtePpnLsb]),
    .invalid    (pte_invalid),
    .leaf       (pte_leaf),
    .misaligned (pte_misaligned)
  );

  // Outputs that start a transaction or report a result are masked by reset
  // and flush, so nothing escapes in a cycle that is being discarded.
  assign live = !rst_i && !flush_i;

  assign asid_field = UpdAsidWidth'(asid_q);

  always_comb begin
    state_d = state_q;
    vaddr_d = vaddr_q;
    asid_d  = asid_q;
    pte_d   = pte_q;
    is_4m_d = is_4m_q;

    case (state_q)
      StIdle: begin
        if (miss_valid_i && !flush_i) begin
          vaddr_d = miss_vaddr_i;
          asid_d  = miss_asid_i;
          state_d = StL1Req;
        end
      end
      StL1Req: begin
        if (flush_i)              state_d = StIdle;
        else if (mem_req_ready_i) state_d = StL1Wait;
      end
      StL1Wait: begin
        if (flush_i) begin
          // A response in the flush cycle is simply dropped; otherwise drain it.
          state_d = mem_rsp_valid_i ? StIdle : StDrain;
        end else if (mem_rsp_valid_i) begin
          pte_d = mem_rsp_data_i;
          if (pte_invalid || (pte_leaf && pte_misaligned)) begin
            state_d = StFault;
          end else if (pte_leaf) begin
            is_4m_d = 1'b1;
            state_d = StUpdate;
          end else begin
            state_d = StL0Req;
          end
        end
      end
      StL0Req: begin
        if (flush_i)              state_d = StIdle;
        else if (mem_req_ready_i) state_d = StL0Wait;
      end
      StL0Wait: begin
        if (flush_i) begin
          state_d = mem_rsp_valid_i ? StIdle : StDrain;
        end else if (mem_rsp_valid_i) begin
          pte_d = mem_rsp_data_i;
          if (pte_leaf) begin
            is_4m_d = 1'b0;
            state_d = StUpdate;
          end else begin
            state_d = StFault;
          end
        end
      end
      StUpdate: state_d = StIdle;
      StFault:  state_d = StIdle;
      StDrain: begin
        if (mem_rsp_valid_i) state_d = StIdle;
      end
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      vaddr_q <= '0;
      asid_q  <= '0;
      pte_q   <= '0;
      is_4m_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vaddr_q <= vaddr_d;
      asid_q  <= asid_d;
      pte_q   <= pte_d;
      is_4m_q <= is_4m_d;
    end
  end

  always_comb begin
    miss_ready_o    = (state_q == StIdle) && !rst_i;
    mem_req_valid_o = ((state_q == StL1Req) || (state_q == StL0Req)) && live;
    walking_o       = (state_q != StIdle);

    mem_req_addr_o = '0;
    if (state_q == StL1Req) begin
      mem_req_addr_o = pte_addr(satp_ppn_i, vaddr_q[VaVpn1Lsb +: VpnWidth]);
    end else if (state_q == StL0Req) begin
      mem_req_addr_o = pte_addr(pte_q[31:PtePpnLsb], vaddr_q[VaVpn0Lsb +: VpnWidth]);
    end

    update_o = '0;
    if ((state_q == StUpdate) && live) begin
      update_o[UpdValidBit]                    = 1'b1;
      update_o[UpdIs4MBit]                     = is_4m_q;
      update_o[UpdVpnLsb +: UpdVpnWidth]       = vaddr_q[31:VaVpn0Lsb];
      update_o[UpdAsidLsb +: UpdAsidWidth]     = asid_field;
      update_o[UpdContentLsb +: 32]            = pte_q;
    end

    fault_valid_o = (state_q == StFault) && live;
    fault_vaddr_o = fault_valid_o ? vaddr_q : 32'd0;
  end

endmodule

// File: tb/tb_sv32_ptw.sv
// Directed bench for sv32_ptw with a PTE memory model and a scoreboard of
// expected request addresses, TLB updates and faults.
module tb_sv32_ptw;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic [21:0] satp_ppn_i = 22'h00010;
  logic        miss_valid_i = 1'b0;
  logic        miss_ready_o;
  logic [31:0] miss_vaddr_i = '0;
  logic [8:0]  miss_asid_i = '0;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b1;
  logic [33:0] mem_req_addr_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_data_i;
  logic [62:0] update_o;
  logic        walking_o;
  logic        fault_valid_o;
  logic [31:0] fault_vaddr_o;

  always #5 clk_i = ~clk_i;

  sv32_ptw #(.ASID_WIDTH(9)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .satp_ppn_i      (satp_ppn_i),
    .miss_valid_i    (miss_valid_i),
    .miss_ready_o    (miss_ready_o),
    .miss_vaddr_i    (miss_vaddr_i),
    .miss_asid_i     (miss_asid_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .update_o        (update_o),
    .walking_o       (walking_o),
    .fault_valid_o   (fault_valid_o),
    .fault_vaddr_o   (fault_vaddr_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int last_upd_cyc = 0;

  logic [33:0] exp_addr_q[$];
  logic [62:0] exp_upd_q[$];
  logic [31:0] exp_fault_q[$];
  logic [33:0] exp_a;
  logic [62:0] exp_u;
  logic [31:0] exp_f;

  logic [31:0] pte_mem [logic [33:0]];
  int          rsp_delay = 0;
  logic        pend;
  int          pend_cnt;
  logic [33:0] pend_addr;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] mem_read(input logic [33:0] a);
    return pte_mem.exists(a) ? pte_mem[a] : 32'h0;
  endfunction

  function automatic logic [62:0] mk_upd(input logic is4m, input logic [31:0] va,
                                         input logic [8:0] as, input logic [31:0] pte);
    return {1'b1, is4m, va[31:12], as, pte};
  endfunction

  // Memory model: delay 0 returns data in the cycle right after the request.
  always @(posedge clk_i) begin
    if (rst_i) begin
      mem_rsp_valid_i <= 1'b0;
      mem_rsp_data_i  <= '0;
      pend            <= 1'b0;
      pend_cnt        <= 0;
      pend_addr       <= '0;
    end else begin
      mem_rsp_valid_i <= 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          mem_rsp_valid_i <= 1'b1;
          mem_rsp_data_i  <= mem_read(pend_addr);
          pend            <= 1'b0;
        end else begin
          pend_cnt <= pend_cnt - 1;
        end
      end
      if (mem_req_valid_o && mem_req_ready_i) begin
        if (rsp_delay == 0) begin
          mem_rsp_valid_i <= 1'b1;
          mem_rsp_data_i  <= mem_read(mem_req_addr_o);
        end else begin
          pend      <= 1'b1;
          pend_cnt  <= rsp_delay - 1;
          pend_addr <= mem_req_addr_o;
        end
      end
    end
  end

  // Scoreboard monitor: every request, update and fault must be expected.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (mem_req_valid_o && mem_req_ready_i) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          failures++;
          $display("FAIL mem_req_addr: unexpected request addr=%h", mem_req_addr_o);
        end else begin
          exp_a = exp_addr_q.pop_front();
          if (mem_req_addr_o !== exp_a) begin
            failures++;
            $display("FAIL mem_req_addr: got %h expected %h", mem_req_addr_o, exp_a);
          end
        end
      end
      if (update_o !== '0) begin
        checks++;
        last_upd_cyc = cyc;
        if (exp_upd_q.size() == 0) begin
          failures++;
          $display("FAIL update: unexpected update_o=%h", update_o);
        end else begin
          exp_u = exp_upd_q.pop_front();
          if (update_o !== exp_u) begin
            failures++;
            $display("FAIL update: got %h expected %h", update_o, exp_u);
          end
        end
      end
      if (fault_valid_o !== 1'b0) begin
        checks++;
        if (exp_fault_q.size() == 0) begin
          failures++;
          $display("FAIL fault: unexpected fault vaddr=%h", fault_vaddr_o);
        end else begin
          exp_f = exp_fault_q.pop_front();
          if (fault_vaddr_o !== exp_f) begin
            failures++;
            $display("FAIL fault_vaddr: got %h expected %h", fault_vaddr_o, exp_f);
          end
        end
      end
    end
  end

  // Present a miss and return at the negedge after the handshake edge.
  task automatic issue_miss(input logic [31:0] va, input logic [8:0] as);
    int n = 0;
    @(negedge clk_i);
    miss_valid_i = 1'b1;
    miss_vaddr_i = va;
    miss_asid_i  = as;
    while (!miss_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (miss_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL miss_handshake: miss_ready_o=%b expected 1 within 50 cycles", miss_ready_o);
    end
    @(negedge clk_i);
    hs_cyc = cyc;
    miss_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (walking_o && n < max_cycles) begin
      @(negedge clk_i);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({miss_ready_o, mem_req_valid_o, fault_valid_o, walking_o} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl: {ready,req,fault,walking}=%b expected 0000",
               {miss_ready_o, mem_req_valid_o, fault_valid_o, walking_o});
    end
    checks++;
    if ({update_o, fault_vaddr_o} !== '0) begin
      failures++;
      $display("FAIL reset_data: update_o=%h fault_vaddr_o=%h expected 0", update_o, fault_vaddr_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (miss_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle_ready: miss_ready_o=%b expected 1", miss_ready_o);
    end
  endtask

  task automatic test_4k_walk();
    pte_mem.delete();
    pte_mem[34'h10400] = 32'h00020001;
    pte_mem[34'h8000C] = 32'h000300CF;
    exp_addr_q.push_back(34'h10400);
    exp_addr_q.push_back(34'h8000C);
    exp_upd_q.push_back(mk_upd(1'b0, 32'h40003000, 9'd1, 32'h000300CF));
    issue_miss(32'h40003000, 9'd1);
    wait_idle(50);
    checks++;
    if (exp_addr_q.size() + exp_upd_q.size() + exp_fault_q.size() != 0 || walking_o !== 1'b0) begin
      failures++;
      $display("FAIL 4k_walk_done: pending=%0d walking=%b expected 0/0",
               exp_addr_q.size() + exp_upd_q.size() + exp_fault_q.size(), walking_o);
    end
    checks++;
    if (last_upd_cyc - hs_cyc != 4) begin
      failures++;
      $display("FAIL 4k_latency: %0d edges after handshake expected 4", last_upd_cyc - hs_cyc);
    end
  endtask

  task automatic test_superpage();
    pte_mem.delete();
    pte_mem[34'h10400] = 32'h0040000F;
    exp_addr_q.push_back(34'h10400);
    exp_upd_q.push_back(mk_upd(1'b1, 32'h40003000, 9'd2, 32'h0040000F));
    issue_miss(32'h40003000, 9'd2);
    wait_idle(50);
    checks++;
    if (exp_addr_q.size() + exp_upd_q.size() + exp_fault_q.size() != 0 || walking_o !== 1'b0) begin
      failures++;
      $display("FAIL superpage_done: pending=%0d walking=%b expected 0/0",
               exp_addr_q.size() + exp_upd_q.size() + exp_fault_q.size(), walking_o);
    end
    checks++;
    if (last_upd_cyc - hs_cyc != 2) begin
      failures++;
      $display("FAIL superpage_latency: %0d edges after handshake expected 2", last_upd_cyc - hs_cyc);
    end
  endtask

  task automatic test_misaligned();
    pte_mem.delete();
    pte_mem[34'h10400] = 32'h0000040F;
    exp_addr_q.push_back(34'h10400);
    exp_fault_q.push_back(32'h40003000);
    issue_miss(32'h40003000, 9'd3);
    wait_idle(50);
    checks++;
    if (exp_addr_q.size() + exp_upd_q.size() + exp_fault_q.size() != 0 || walking_o !== 1'b0) begin
      failures++;
      $display("FAIL misaligned_done: pending=%0d walking=%b expected 0/0",
               exp_addr_q.size() + exp_upd_q.size() + exp_fault_q.size(), walking_o);
    end
  endtask

  task automatic test_invalid_leaf();
    pte_mem.delete();
    pte_mem[34'h10400] = 32'h00020001;
    pte_mem[34'h8000C] = 32'h00000000;
    exp_addr_q.push_back(34'h10400);
    exp_addr_q.push_back(34'h8000C);
    exp_fault_q.push_back(32'h40003000);
    issue_miss(32'h40003000, 9'd4);
    wait_idle(50);
    checks++;
    if (exp_addr_q.size() + exp_upd_q.size() + exp_fault_q.size() != 0 || walking_o !== 1'b0) begin
      failures++;
      $display("FAIL invalid_leaf_done: pending=%0d walking=%b expected 0/0",
               exp_addr_q.size() + exp_upd_q.size() + exp_fault_q.size(), walking_o);
    end
  endtask

  task automatic test_flush_l1_wait();
    int n = 0;
    pte_mem.delete();
    pte_mem[34'h10004] = 32'h0040000F;  // a leaf: an update would appear if not discarded
    rsp_delay = 4;
    exp_addr_q.push_back(34'h10004);
    issue_miss(32'h00400000, 9'd7);
    @(negedge clk_i);                   // L1_WAIT
    flush_i = 1'b1;
    @(negedge clk_i);                   // DRAIN
    flush_i = 1'b0;
    checks++;
    if ({walking_o, miss_ready_o, mem_req_valid_o} !== 3'b100) begin
      failures++;
      $display("FAIL flush_drain_state: {walking,ready,req}=%b expected 100",
               {walking_o, miss_ready_o, mem_req_valid_o});
    end
    while (!mem_rsp_valid_i && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (mem_rsp_valid_i !== 1'b1 || miss_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_drain_rsp: rsp_valid=%b ready=%b expected 1/0",
               mem_rsp_valid_i, miss_ready_o);
    end
    @(negedge clk_i);
    checks++;
    if (miss_ready_o !== 1'b1 || walking_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready_after_rsp: ready=%b walking=%b expected 1/0",
               miss_ready_o, walking_o);
    end
    rsp_delay = 0;
  endtask

  task automatic test_reset_mid_walk();
    pte_mem.delete();
    pte_mem[34'h10400] = 32'h00020001;
    pte_mem[34'h8000C] = 32'h000300CF;
    rsp_delay = 0;
    exp_addr_q.push_back(34'h10400);
    exp_addr_q.push_back(34'h8000C);
    issue_miss(32'h40003000, 9'd9);     // now in L1_REQ
    @(negedge clk_i);                   // L1_WAIT, response present
    rsp_delay = 6;
    @(negedge clk_i);                   // L0_REQ
    @(negedge clk_i);                   // L0_WAIT, response held off
    checks++;
    if (walking_o !== 1'b1 || mem_req_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_walk_wait: walking=%b req=%b expected 1/0", walking_o, mem_req_valid_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({miss_ready_o, mem_req_valid_o, fault_valid_o, walking_o} !== 4'b0 ||
        {update_o, fault_vaddr_o} !== '0) begin
      failures++;
      $display("FAIL mid_walk_reset: ctrl=%b update_o=%h fault_vaddr_o=%h expected all 0",
               {miss_ready_o, mem_req_valid_o, fault_valid_o, walking_o}, update_o, fault_vaddr_o);
    end
    rst_i = 1'b0;
    rsp_delay = 0;
    @(negedge clk_i);
    checks++;
    if (miss_ready_o !== 1'b1 || exp_addr_q.size() != 0) begin
      failures++;
      $display("FAIL mid_walk_idle: ready=%b pending_req=%0d expected 1/0",
               miss_ready_o, exp_addr_q.size());
    end
    exp_addr_q.push_back(34'h10400);
    exp_addr_q.push_back(34'h8000C);
    exp_upd_q.push_back(mk_upd(1'b0, 32'h40003000, 9'd10, 32'h000300CF));
    issue_miss(32'h40003000, 9'd10);
    wait_idle(50);
    checks++;
    if (exp_addr_q.size() + exp_upd_q.size() + exp_fault_q.size() != 0 || walking_o !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_walk: pending=%0d walking=%b expected 0/0",
               exp_addr_q.size() + exp_upd_q.size() + exp_fault_q.size(), walking_o);
    end
  endtask

  initial begin
    test_reset();
    test_4k_walk();
    test_superpage();
    test_misaligned();
    test_invalid_leaf();
    test_flush_l1_wait();
    test_reset_mid_walk();
    repeat (3) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
